// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: frame geometry and the
// serializer state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  localparam int CLKS_PER_BIT   = 87;

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous byte FIFO. The pointers carry one extra wrap bit, so full and empty
// are told apart without a separate counter.
module uart_tx_fifo_buf
  import uart_pkg::*;
#(
  parameter int FifoDepth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push,
  input  logic [UART_DATA_BITS-1:0]     wdata,
  input  logic                          pop,
  output logic [UART_DATA_BITS-1:0]     rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FifoDepth):0]    level
);

  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;

  logic [UART_DATA_BITS-1:0] mem [FifoDepth];
  logic [AW:0]               wr_ptr;
  logic [AW:0]               rd_ptr;
  logic                      push_ok;
  logic                      pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(FifoDepth));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO. Frames are sent back to back
// while the FIFO holds data; tx_o comes straight from a flop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FifoDepth = 4,
  parameter int CpbW      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [CpbW-1:0]            clks_per_bit_i,
  input  logic                       tx_valid_i,
  input  logic [7:0]                 tx_byte_i,
  output logic                       tx_ready_o,
  output logic                       tx_o,
  output logic                       tx_busy_o,
  output logic                       tx_done_o,
  output logic [$clog2(FifoDepth):0] fifo_level_o
);

  uart_tx_state_e state;
  logic [7:0]      shift_q;
  logic [7:0]      rdata;
  logic [CpbW-1:0] cpb_q;
  logic [CpbW-1:0] cpb_next;
  logic [CpbW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic            tx_q;
  logic            done_q;
  logic            full;
  logic            empty;
  logic            last;
  logic            load;
  logic            done_next;

  uart_tx_fifo_buf #(
    .FifoDepth(FifoDepth)
  ) u_buf (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (tx_valid_i),
    .wdata (tx_byte_i),
    .pop   (load),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level_o)
  );

  assign last     = (baud_q == cpb_q - CpbW'(1));
  assign load     = !empty && ((state == IDLE) || ((state == STOP) && last));
  assign cpb_next = (clks_per_bit_i == '0) ? CpbW'(1) : clks_per_bit_i;

  // done is registered one cycle early so that it is high during the last stop cycle.
  assign done_next = ((state == DATA) && last && (bit_q == 3'(UART_DATA_BITS - 1)) && (cpb_q == CpbW'(1)))
                   || ((state == STOP) && !last && (baud_q + CpbW'(1) == cpb_q - CpbW'(1)));

  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;
  assign tx_ready_o = !full;
  assign tx_busy_o  = (state != IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (load) begin
      shift_q <= rdata;
      cpb_q   <= cpb_next;
    end else if ((state == DATA) && last) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= done_next;
      case (state)
        IDLE: begin
          if (!empty) begin
            baud_q <= '0;
            state  <= START;
            tx_q   <= 1'b0;
          end
        end
        START: begin
          if (last) begin
            baud_q <= '0;
            bit_q  <= '0;
            state  <= DATA;
            tx_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + CpbW'(1);
          end
        end
        DATA: begin
          if (last) begin
            baud_q <= '0;
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CpbW'(1);
          end
        end
        STOP: begin
          if (last) begin
            baud_q <= '0;
            if (!empty) begin
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CpbW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line decoder pops expected bytes from a
// scoreboard queue filled as bytes are accepted.
module tb_uart_tx_fifo;

  localparam int FifoDepth = 4;
  localparam int CpbW      = 16;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [CpbW-1:0] cpb;
  logic            tx_valid;
  logic [7:0]      tx_byte;
  logic            ready;
  logic            tx;
  logic            busy;
  logic            done;
  logic [2:0]      level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frames = 0;
  logic [7:0] sb[$];

  uart_tx_fifo #(.FifoDepth(FifoDepth), .CpbW(CpbW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clks_per_bit_i(cpb),
    .tx_valid_i    (tx_valid),
    .tx_byte_i     (tx_byte),
    .tx_ready_o    (ready),
    .tx_o          (tx),
    .tx_busy_o     (busy),
    .tx_done_o     (done),
    .fifo_level_o  (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line decoder, sampling at the falling clock edge
  logic smp [0:1023];
  logic dn  [0:1023];
  int   idx = 0;
  int   fcpb = 1;
  int   cpb_last = 1;
  bit   in_frame = 1'b0;
  logic prev_tx = 1'b1;

  task automatic eval_frame();
    bit         shape_ok = 1'b1;
    bit         dn_ok = 1'b1;
    logic [9:0] bits;
    for (int b = 0; b < 10; b++) begin
      bits[b] = smp[b*fcpb];
      for (int k = 0; k < fcpb; k++)
        if (smp[b*fcpb+k] !== bits[b]) shape_ok = 1'b0;
    end
    check("frame_shape", {29'd0, shape_ok, bits[0], bits[9]}, 32'b101);
    for (int k = 0; k < 10*fcpb; k++)
      if (dn[k] !== (k == 10*fcpb-1)) dn_ok = 1'b0;
    check("frame_done", {31'd0, dn_ok}, 32'd1);
    check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) check("frame_byte", {24'd0, bits[8:1]}, {24'd0, sb.pop_front()});
    frames++;
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      in_frame = 1'b0;
      prev_tx  = 1'b1;
    end else if (in_frame) begin
      smp[idx] = tx;
      dn[idx]  = done;
      idx++;
      if (idx == 10*fcpb) begin
        eval_frame();
        in_frame = 1'b0;
      end
      prev_tx = tx;
    end else begin
      if (tx === 1'b0 && prev_tx === 1'b1) begin
        in_frame = 1'b1;
        fcpb     = (cpb_last == 0) ? 1 : cpb_last;
        smp[0]   = tx;
        dn[0]    = done;
        idx      = 1;
      end else begin
        check("idle_done", {31'd0, done}, 32'd0);
      end
      prev_tx = tx;
    end
    cpb_last = int'(cpb);
  end

  task automatic send(input logic [7:0] b);
    int   n = 0;
    logic r;
    tx_valid = 1'b1;
    tx_byte  = b;
    do begin
      r = ready;
      step();
      n++;
    end while (!r && n < 2000);
    check("send_accept", {31'd0, r}, 32'd1);
    if (r) sb.push_back(b);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int t0, output int dt);
    int n = 0;
    while (busy && n < 5000) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    dt = cyc - t0;
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] bs [6];
    int         i, n, waited, t0, dt, f0;
    logic       r;

    rst_ni = 1'b0; cpb = 16'd4; tx_valid = 1'b0; tx_byte = 8'h00;
    step(); step();
    rst_ni = 1'b1;
    check("reset_state", {25'd0, tx, ready, busy, done, level}, 32'b1100000);

    // Idle line after reset
    repeat (100) begin
      step();
      check("idle_state", {25'd0, tx, ready, busy, done, level}, 32'b1100000);
    end

    // Single frame 0xA5, cycle-exact
    pat = {1'b1, 8'hA5, 1'b0};
    send(8'hA5);
    check("no_bypass", {27'd0, tx, busy, level}, 32'b11001);
    step();
    check("start_latency", {28'd0, tx, level}, 32'b0000);
    for (int k = 0; k < 40; k++) begin
      check("a5_line", {30'd0, tx, done}, {30'd0, pat[k/4], k == 39});
      step();
    end
    check("a5_idle", {30'd0, tx, busy}, 32'b10);

    // Back-to-back bytes against a full FIFO
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    i = 0; n = 0; waited = 0; t0 = cyc;
    tx_valid = 1'b1;
    while (i < 6 && n < 1000) begin
      tx_byte = bs[i];
      r = ready;
      step();
      n++;
      if (r) begin
        sb.push_back(bs[i]);
        i++;
        if (i == 1) check("b2b_first_level", {28'd0, tx, level}, 32'b1001);
        if (i == 2) begin
          check("b2b_popped", {28'd0, tx, level}, 32'b0001);
          t0 = cyc;
        end
        if (i == 5) check("b2b_full", {28'd0, ready, level}, 32'b0100);
      end else if (i == 5) begin
        waited++;
      end
    end
    tx_valid = 1'b0;
    check("b2b_all_accepted", i, 6);
    check("b2b_backpressure", {31'd0, waited >= 30}, 32'd1);
    wait_idle(t0, dt);
    check("b2b_line_time", dt, 240);

    // Bit period change mid-frame applies to the next frame only
    cpb = 16'd4;
    send(8'h0F);
    send(8'hF0);
    t0 = cyc;
    repeat (10) step();
    cpb = 16'd8;
    wait_idle(t0, dt);
    check("cpb_change_time", dt, 120);

    // Reset during data bit 3
    cpb = 16'd4;
    send(8'h5A);
    send(8'h77);
    repeat (17) step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("abort_state", {25'd0, tx, ready, busy, done, level}, 32'b1100000);
    sb.delete();
    repeat (45) begin
      step();
      check("abort_quiet", {29'd0, tx, busy, done}, 32'b100);
    end
    f0 = frames;
    send(8'h3C);
    step();
    t0 = cyc;
    wait_idle(t0, dt);
    check("recover_time", dt, 40);
    check("recover_frames", frames - f0, 1);

    // Zero clocks-per-bit behaves as one
    cpb = 16'd0;
    f0 = frames;
    send(8'h00);
    send(8'hFF);
    t0 = cyc;
    send(8'h55);
    wait_idle(t0, dt);
    check("cpb0_time", dt, 30);
    check("cpb0_frames", frames - f0, 3);

    // Board bit rate
    cpb = 16'd87;
    f0 = frames;
    send(8'h00);
    send(8'hFF);
    t0 = cyc;
    send(8'h55);
    wait_idle(t0, dt);
    check("cpb87_time", dt, 2610);
    check("cpb87_frames", frames - f0, 3);

    step();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-oriented UART transmitter and the transmit-side counterpart of the existing uart_rx programmer. It sends 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) on a serial line. A small input FIFO decouples the sender from the line rate. It sits beside the receiver and lets the SoC, or a future boot/ICCM loader, echo or report status over the same UART pins.

Parameters:
FifoDepth, 4, number of byte entries in the input FIFO; power of two, 2..16.
CpbW, 16, width of the runtime clocks-per-bit input.

Ports:
clk_i  input  1  system clock.
rst_ni  input  1  reset; synchronous, active-low.
clks_per_bit_i  input  CpbW  clock cycles per UART bit (87 for the current board setting).
tx_valid_i  input  1  producer offers tx_byte_i.
tx_byte_i  input  8  byte to transmit.
tx_ready_o  output  1  FIFO can accept a byte; equals not-full.
tx_o  output  1  serial line; idles high.
tx_busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
tx_done_o  output  1  one-cycle pulse at the end of each stop bit.
fifo_level_o  output  $clog2(FifoDepth)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous and active-low, sampled on the clk_i rising edge. While rst_ni=0 at an edge:
  - tx_o=1, tx_ready_o=1 (after that edge), tx_busy_o=0, tx_done_o=0, fifo_level_o=0.
  - FIFO pointers are cleared; FSM returns to IDLE; bit and baud counters are set to 0.
- Reset mid-frame aborts the frame: tx_o is high from the next edge, and the queued bytes are discarded.
- Handshake: a byte is accepted at an edge where tx_valid_i and tx_ready_o are both 1.
  - With the FIFO full, tx_ready_o=0 and tx_valid_i is ignored.
  - tx_byte_i only needs to be stable in the accept cycle.
- FIFO: FifoDepth entries, write and read pointers with an extra wrap bit.
  - Push and pop in the same cycle keep the level unchanged.
  - Pointers wrap modulo FifoDepth.
  - There is no bypass: a byte pushed into an empty FIFO is popped at the next edge at the earliest.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at an edge, do all of the following at that edge: pop the head into the shift register, latch clks_per_bit_i into cpb_q (a value of 0 is latched as 1), clear the baud counter, enter START, and register tx_o=0.
  - START: tx_o=0 for cpb_q cycles, then enter DATA with bit index 0.
  - DATA: tx_o=shift[0] for cpb_q cycles, then shift right and increment the bit index. After bit index 7 completes, enter STOP.
  - STOP: tx_o=1 for cpb_q cycles. At the final cycle, pulse tx_done_o for one cycle.
    - If the FIFO is non-empty, pop and go directly to START, with no idle gap between frames.
    - Otherwise go to IDLE.
- Timing:
  - The baud counter counts 0..cpb_q-1; each bit lasts exactly cpb_q clocks.
  - A frame lasts exactly 10*cpb_q clocks.
  - Changes to clks_per_bit_i take effect only at the next frame start.
- Latency: the accept edge of a byte into an empty, idle block is edge t. The pop occurs at edge t+1, and tx_o goes low after edge t+1, i.e. one cycle after the accept cycle.
- tx_busy_o = (state!=IDLE) | (level!=0). tx_o is driven straight from a flop, so it carries no glitches.

Decomposition:
- uart_pkg holds: the uart_tx_state_e enum (IDLE, START, DATA, STOP), the constants UART_DATA_BITS=8 and UART_STOP_BITS=1, and the default CLKS_PER_BIT=87.
- One sub-module, uart_tx_fifo_buf: a synchronous byte FIFO with push/pop/full/empty/level, parameterised by FifoDepth.
- The serializer FSM lives in the top module.

Test Plan:
1. Reset, then idle with clks_per_bit_i=4: tx_o=1, tx_ready_o=1, tx_busy_o=0, fifo_level_o=0 for 100 cycles.
2. clks_per_bit_i=4, push 0xA5 with the block idle: tx_o reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). The start bit begins one cycle after the accept cycle. tx_done_o pulses once, at the last stop cycle.
3. FifoDepth=4, push 6 bytes back-to-back with tx_valid_i held high:
   - The first byte is popped the cycle after it is accepted.
   - Bytes 2–5 are accepted; the FIFO then fills, and tx_ready_o stays 0 until a pop frees an entry.
   - Total line time is 6 frames with no idle gaps, and the received bytes match in order.
4. Change clks_per_bit_i from 4 to 8 mid-frame: the current frame stays at 40 cycles, and the next frame lasts 80 cycles.
5. Assert rst_ni=0 for one edge during DATA bit 3: tx_o=1 from the next edge, fifo_level_o=0, and no tx_done_o pulse. A fresh 0x3C then transmits correctly.
6. clks_per_bit_i=0: each bit lasts 1 cycle, so the frame is 10 cycles. Run a loopback into uart_rx with CLKS_PER_BIT=87 and 87 on the tx side; 0x00, 0xFF and 0x55 are received intact.
